dino_game_ctrl: RTL and testbench

Top-level game sequencer for the dinosaur runner. It owns the game state machine (idle / running / over) and generates the frame tick. It runs the dinosaur vertical physics with velocity and gravity, moves the single obstacle, detects collisions and keeps the score. Its outputs drive the VGA renderer and score display directly; `game_status` and `dinosaur_height` keep their existing meanings (height 63 = on ground, smaller = higher on screen).

---
 rtl/dino_game_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dino_game_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dino_game_ctrl.sv
// rtl/dino_game_ctrl.sv - dinosaur runner game sequencer
//
// Purpose: owns the IDLE/RUN/OVER game state machine, the frame tick,
// dinosaur vertical physics (velocity + gravity), the single obstacle,
// collision detection and the score.
//
// Ports:
//   CLK             in   system clock, rising edge
//   RST             in   synchronous active-high reset
//   button_jump     in   debounced jump button level
//   game_status     out  1 while running
//   game_over       out  1 while in game-over state
//   tick            out  one-cycle frame strobe
//   dinosaur_height out  dinosaur y, 63 = ground, smaller = higher
//   obstacle_x      out  obstacle x column
//   score           out  obstacles passed, saturating at 1023
module dino_game_ctrl #(
   parameter int TICK_DIV = 500000,
   parameter int JUMP_V0  = 6,
   parameter int DINO_X   = 16,
   parameter int DINO_W   = 8,
   parameter int OBST_Y   = 56
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       button_jump,
   output logic       game_status,
   output logic       game_over,
   output logic       tick,
   output logic [5:0] dinosaur_height,
   output logic [7:0] obstacle_x,
   output logic [9:0] score
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

   localparam int              CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]   CNT_MAX  = CW'(TICK_DIV - 1);
   localparam logic [5:0]      H_GROUND = 6'd63;
   localparam logic [5:0]      H_JUMP   = 6'(63 - JUMP_V0);
   localparam logic [4:0]      V_JUMP   = 5'(1 - JUMP_V0);
   localparam logic [7:0]      X_LO     = 8'(DINO_X);
   localparam logic [7:0]      X_HI     = 8'(DINO_X + DINO_W - 1);
   localparam logic [5:0]      Y_HIT    = 6'(OBST_Y);

   state_t        r_state;
   state_t        w_next_state;
   logic [CW-1:0] r_cnt;
   logic          r_tick;
   logic          r_btn_q;
   logic [5:0]    r_height;
   logic [4:0]    r_vel;        // two's complement, negative = moving up
   logic          r_jump_pend;
   logic [7:0]    r_obst_x;
   logic [9:0]    r_score;

   logic          w_press;
   logic          w_hit;
   logic          w_step;
   logic          w_restart;
   logic [6:0]    w_n;
   logic          w_landing;
   logic [6:0]    w_speed_sum;
   logic [7:0]    w_speed;

   assign w_press   = button_jump & ~r_btn_q;
   // Collision looks at the values held before this tick's update.
   assign w_hit     = (r_obst_x >= X_LO) && (r_obst_x <= X_HI) && (r_height >= Y_HIT);
   assign w_step    = (r_state == S_RUN) && r_tick && !w_hit;
   assign w_restart = (r_state == S_OVER) && w_press;

   // Candidate height as a 7-bit signed sum; bit 6 set means above the top.
   assign w_n       = {1'b0, r_height} + {{2{r_vel[4]}}, r_vel};
   assign w_landing = (w_n == 7'd63) && !r_vel[4] && (r_vel != 5'd0);

   // Obstacle speed grows every 16 points, capped at 4 columns per tick.
   assign w_speed_sum = 7'd1 + {1'b0, r_score[9:4]};
   assign w_speed     = (w_speed_sum > 7'd4) ? 8'd4 : {1'b0, w_speed_sum};

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt   <= '0;
         r_tick  <= 1'b0;
         r_btn_q <= 1'b0;
      end else begin
         r_btn_q <= button_jump;
         r_tick  <= (r_cnt == CNT_MAX);
         r_cnt   <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      game_status  = 1'b0;
      game_over    = 1'b0;
      case (r_state)
         S_IDLE: if (w_press) w_next_state = S_RUN;
         S_RUN: begin
            game_status = 1'b1;
            if (r_tick && w_hit) w_next_state = S_OVER;
         end
         S_OVER: begin
            game_over = 1'b1;
            if (w_press) w_next_state = S_RUN;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST || w_restart) begin
         r_height    <= H_GROUND;
         r_vel       <= 5'd0;
         r_jump_pend <= 1'b0;
         r_obst_x    <= 8'd255;
         r_score     <= 10'd0;
      end else begin
         // A tick consumes the pending request; a press on the tick cycle
         // re-arms it for the following tick.
         if (r_state == S_RUN) begin
            if (r_tick)       r_jump_pend <= w_press;
            else if (w_press) r_jump_pend <= 1'b1;
         end
         if (w_step) begin
            if (r_jump_pend && (r_height == H_GROUND)) begin
               r_height <= H_JUMP;
               r_vel    <= V_JUMP;
            end else if (r_height != H_GROUND) begin
               if (w_n[6]) begin
                  r_height <= 6'd0;
                  r_vel    <= r_vel + 5'd1;
               end else if (w_landing) begin
                  r_height <= H_GROUND;
                  r_vel    <= 5'd0;
               end else begin
                  r_height <= w_n[5:0];
                  r_vel    <= r_vel + 5'd1;
               end
            end
            if (r_obst_x < w_speed) begin
               r_obst_x <= 8'd255;
               r_score  <= (r_score == 10'h3FF) ? r_score : r_score + 10'd1;
            end else begin
               r_obst_x <= r_obst_x - w_speed;
            end
         end
      end
   end

   assign tick            = r_tick;
   assign dinosaur_height = r_height;
   assign obstacle_x      = r_obst_x;
   assign score           = r_score;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb/tb_dino_game_ctrl.sv - self-checking bench for dino_game_ctrl
module tb_dino_game_ctrl;

   localparam int TD = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       button_jump = 1'b0;
   logic       game_status;
   logic       game_over;
   logic       tick;
   logic [5:0] dinosaur_height;
   logic [7:0] obstacle_x;
   logic [9:0] score;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] sb_q[$];
   logic [31:0] exp_v;
   int jump_seq[13] = '{57, 52, 48, 45, 43, 42, 42, 43, 45, 48, 52, 57, 63};

   dino_game_ctrl #(.TICK_DIV(TD)) dut (
      .CLK(CLK), .RST(RST), .button_jump(button_jump),
      .game_status(game_status), .game_over(game_over), .tick(tick),
      .dinosaur_height(dinosaur_height), .obstacle_x(obstacle_x), .score(score)
   );

   always #5 CLK = ~CLK;

   task automatic clk_cycle();
      @(posedge CLK);
      #1;
   endtask

   // Advance to just after the next tick edge so updated values are visible.
   task automatic next_update();
      int k;
      k = 0;
      while (tick !== 1'b1 && k < 3 * TD) begin
         clk_cycle();
         k++;
      end
      if (tick !== 1'b1) begin
         n_total++;
         $display("FAIL tick_timeout: tick=%b required 1", tick);
      end
      clk_cycle();
   endtask

   task automatic press_btn();
      button_jump = 1'b1;
      clk_cycle();
      button_jump = 1'b0;
   endtask

   task automatic test_reset();
      int k;
      int c;
      RST = 1'b1;
      button_jump = 1'b0;
      repeat (3) clk_cycle();
      n_total++; if (game_status !== 1'b0) $display("FAIL rst_status: got %b want 0", game_status); else n_pass++;
      n_total++; if (game_over !== 1'b0) $display("FAIL rst_over: got %b want 0", game_over); else n_pass++;
      n_total++; if (tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", tick); else n_pass++;
      n_total++; if (dinosaur_height !== 6'd63) $display("FAIL rst_height: got %0d want 63", dinosaur_height); else n_pass++;
      n_total++; if (obstacle_x !== 8'd255) $display("FAIL rst_obst: got %0d want 255", obstacle_x); else n_pass++;
      n_total++; if (score !== 10'd0) $display("FAIL rst_score: got %0d want 0", score); else n_pass++;
      RST = 1'b0;
      k = 0;
      while (tick !== 1'b1 && k < 10) begin
         clk_cycle();
         k++;
      end
      n_total++; if (tick !== 1'b1) $display("FAIL first_tick: got %b want 1", tick); else n_pass++;
      for (int p = 0; p < 3; p++) begin
         c = 0;
         do begin
            clk_cycle();
            c++;
         end while (tick !== 1'b1 && c < 10);
         n_total++; if (c != TD) $display("FAIL tick_period: got %0d want %0d", c, TD); else n_pass++;
         n_total++; if (game_status !== 1'b0) $display("FAIL idle_status: got %b want 0", game_status); else n_pass++;
      end
   endtask

   task automatic test_start_and_jump();
      press_btn();
      n_total++; if (game_status !== 1'b1) $display("FAIL start_status: got %b want 1", game_status); else n_pass++;
      n_total++; if (game_over !== 1'b0) $display("FAIL start_over: got %b want 0", game_over); else n_pass++;
      clk_cycle();
      foreach (jump_seq[i]) sb_q.push_back(32'(jump_seq[i]));
      press_btn();
      for (int i = 0; i < 13; i++) begin
         next_update();
         exp_v = sb_q.pop_front();
         n_total++; if ({26'd0, dinosaur_height} !== exp_v) $display("FAIL jump_h[%0d]: got %0d want %0d", i, dinosaur_height, exp_v); else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
         next_update();
         n_total++; if (dinosaur_height !== 6'd63) $display("FAIL ground_h[%0d]: got %0d want 63", i, dinosaur_height); else n_pass++;
      end
      n_total++; if (game_status !== 1'b1) $display("FAIL jump_status: got %b want 1", game_status); else n_pass++;
   endtask

   task automatic test_press_airborne();
      clk_cycle();
      foreach (jump_seq[i]) sb_q.push_back(32'(jump_seq[i]));
      press_btn();
      for (int i = 0; i < 13; i++) begin
         next_update();
         exp_v = sb_q.pop_front();
         n_total++; if ({26'd0, dinosaur_height} !== exp_v) $display("FAIL air_h[%0d]: got %0d want %0d", i, dinosaur_height, exp_v); else n_pass++;
         if (i == 3) begin
            clk_cycle();
            press_btn();
         end
      end
      for (int i = 0; i < 2; i++) begin
         next_update();
         n_total++; if (dinosaur_height !== 6'd63) $display("FAIL air_ground[%0d]: got %0d want 63", i, dinosaur_height); else n_pass++;
      end
   endtask

   task automatic test_obstacle_run();
      // Play on, hopping each obstacle, until 15 have been passed.
      for (int i = 0; i < 6000; i++) begin
         if (score == 10'd15) break;
         next_update();
         if (obstacle_x == 8'd26) begin
            clk_cycle();
            press_btn();
         end
      end
      n_total++; if (score !== 10'd15) $display("FAIL reach_score: got %0d want 15", score); else n_pass++;
      n_total++; if (obstacle_x !== 8'd255) $display("FAIL reach_obst: got %0d want 255", obstacle_x); else n_pass++;
      n_total++; if (game_status !== 1'b1) $display("FAIL reach_status: got %b want 1", game_status); else n_pass++;
      for (int v = 254; v >= 0; v--) sb_q.push_back(32'(v));
      sb_q.push_back(32'd255);
      sb_q.push_back(32'd253);
      for (int j = 0; j < 257; j++) begin
         next_update();
         exp_v = sb_q.pop_front();
         n_total++; if ({24'd0, obstacle_x} !== exp_v) $display("FAIL obst_x[%0d]: got %0d want %0d", j, obstacle_x, exp_v); else n_pass++;
         if (j == 254) begin
            n_total++; if (score !== 10'd15) $display("FAIL score_pre: got %0d want 15", score); else n_pass++;
         end
         if (j == 255) begin
            n_total++; if (score !== 10'd16) $display("FAIL score_wrap: got %0d want 16", score); else n_pass++;
         end
         if (exp_v == 32'd26) begin
            clk_cycle();
            press_btn();
         end
      end
   endtask

   task automatic test_collision();
      for (int i = 0; i < 200; i++) begin
         if (obstacle_x == 8'd23) break;
         next_update();
      end
      n_total++; if (obstacle_x !== 8'd23) $display("FAIL col_reach: got %0d want 23", obstacle_x); else n_pass++;
      n_total++; if (game_status !== 1'b1) $display("FAIL col_pre_status: got %b want 1", game_status); else n_pass++;
      next_update();
      n_total++; if (game_over !== 1'b1) $display("FAIL col_over: got %b want 1", game_over); else n_pass++;
      n_total++; if (game_status !== 1'b0) $display("FAIL col_status: got %b want 0", game_status); else n_pass++;
      n_total++; if (obstacle_x !== 8'd23) $display("FAIL col_obst: got %0d want 23", obstacle_x); else n_pass++;
      n_total++; if (score !== 10'd16) $display("FAIL col_score: got %0d want 16", score); else n_pass++;
      next_update();
      next_update();
      n_total++; if (obstacle_x !== 8'd23) $display("FAIL over_obst: got %0d want 23", obstacle_x); else n_pass++;
      n_total++; if (score !== 10'd16) $display("FAIL over_score: got %0d want 16", score); else n_pass++;
      n_total++; if (dinosaur_height !== 6'd63) $display("FAIL over_h: got %0d want 63", dinosaur_height); else n_pass++;
   endtask

   task automatic test_restart();
      clk_cycle();
      press_btn();
      n_total++; if (game_status !== 1'b1) $display("FAIL rs_status: got %b want 1", game_status); else n_pass++;
      n_total++; if (game_over !== 1'b0) $display("FAIL rs_over: got %b want 0", game_over); else n_pass++;
      n_total++; if (dinosaur_height !== 6'd63) $display("FAIL rs_h: got %0d want 63", dinosaur_height); else n_pass++;
      n_total++; if (obstacle_x !== 8'd255) $display("FAIL rs_obst: got %0d want 255", obstacle_x); else n_pass++;
      n_total++; if (score !== 10'd0) $display("FAIL rs_score: got %0d want 0", score); else n_pass++;
   endtask

   task automatic test_reset_midjump();
      int k;
      clk_cycle();
      press_btn();
      repeat (3) next_update();
      n_total++; if (dinosaur_height !== 6'd48) $display("FAIL mid_h: got %0d want 48", dinosaur_height); else n_pass++;
      k = 0;
      while (tick !== 1'b1 && k < 3 * TD) begin
         clk_cycle();
         k++;
      end
      RST = 1'b1;
      button_jump = 1'b1;
      clk_cycle();
      n_total++; if (game_status !== 1'b0) $display("FAIL mr_status: got %b want 0", game_status); else n_pass++;
      n_total++; if (game_over !== 1'b0) $display("FAIL mr_over: got %b want 0", game_over); else n_pass++;
      n_total++; if (tick !== 1'b0) $display("FAIL mr_tick: got %b want 0", tick); else n_pass++;
      n_total++; if (dinosaur_height !== 6'd63) $display("FAIL mr_h: got %0d want 63", dinosaur_height); else n_pass++;
      n_total++; if (obstacle_x !== 8'd255) $display("FAIL mr_obst: got %0d want 255", obstacle_x); else n_pass++;
      n_total++; if (score !== 10'd0) $display("FAIL mr_score: got %0d want 0", score); else n_pass++;
      RST = 1'b0;
      button_jump = 1'b0;
      next_update();
      next_update();
      n_total++; if (game_status !== 1'b0) $display("FAIL mr_idle: got %b want 0", game_status); else n_pass++;
      n_total++; if (obstacle_x !== 8'd255) $display("FAIL mr_idle_obst: got %0d want 255", obstacle_x); else n_pass++;
      press_btn();
      n_total++; if (game_status !== 1'b1) $display("FAIL mr_start: got %b want 1", game_status); else n_pass++;
      next_update();
      n_total++; if (dinosaur_height !== 6'd63) $display("FAIL mr_nojump: got %0d want 63", dinosaur_height); else n_pass++;
      n_total++; if (obstacle_x !== 8'd254) $display("FAIL mr_first_step: got %0d want 254", obstacle_x); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_start_and_jump();
      test_press_airborne();
      test_obstacle_run();
      test_collision();
      test_restart();
      test_reset_midjump();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
